pim_bus_slave: RTL and testbench

- Bus responder on the PIM side of the DMA-to-PIM transfer path. It answers the word-wide read/write bus at the PIM control, result and weight/activation write addresses.
- Buffers incoming weight/activation words in a command FIFO and drains them to the PIM macro array over valid/ready.
- Buffers macro results in a result FIFO, which the bus pops by reading.
- Publishes the busy/data-valid status word that DMA masters poll before each transfer.

---
 rtl/pim_bus_pkg.sv | 29 ++
 rtl/pim_bus_slave_fifo.sv | 60 ++++++
 rtl/pim_bus_slave.sv | 143 ++++++++++++++
 tb/tb_pim_bus_slave.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_bus_pkg.sv
// Shared definitions for the PIM-side bus responder.
//   - Bus address map of the PIM control, result and write ports
//   - Bit positions of the status word
//   - Command word layout carried by the command FIFO
//   - Byte-lane mask helper for partial-width bus writes
package pim_bus_pkg;

  localparam logic [31:0] PIM_CTRL         = 32'h4000_0010;
  localparam logic [31:0] PIM_R            = 32'h4000_0020;
  localparam logic [31:0] PIM_W_WEIGHT     = 32'h4000_0040;
  localparam logic [31:0] PIM_W_ACTIVATION = 32'h4000_0080;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_VALID = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_UDF   = 3;

  typedef struct packed {
    logic        is_act;
    logic [3:0]  sel;
    logic [31:0] data;
  } pim_cmd_t;

  // Expand the 4 byte-lane enables into a 32-bit keep mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] size);
    return {{8{size[3]}}, {8{size[2]}}, {8{size[1]}}, {8{size[0]}}};
  endfunction

endpackage

// File: rtl/pim_bus_slave_fifo.sv
// pim_sync_fifo: single-clock FIFO with occupancy count.
//   clk, rst_n          clock, async active-low reset (empties the FIFO)
//   push, push_data     write request and word; ignored when full unless
//                       a pop happens in the same cycle
//   pop, pop_data       read request and head word (head shown combinationally)
//   full, empty, count  occupancy status; count is log2(DEPTH)+1 bits
module pim_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is not reset; emptiness comes from the pointers and count,
  // so clearing those is enough to discard buffered words.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pim_bus_slave.sv
// pim_bus_slave: bus responder on the PIM side of the DMA-to-PIM path.
//   i_clk, i_rst_n        clock, async active-low reset
//   i_addr/i_write/i_read/i_size/i_wr_data
//                         word-wide bus request; write wins over read
//   o_rd_data             registered read data (1-cycle latency, held)
//   o_w_valid/o_w_is_act/o_w_sel/o_w_data, i_w_ready
//                         command FIFO head drained to the macro array
//   i_r_valid/i_r_data, o_r_ready
//                         macro results filled into the result FIFO
//   i_pim_busy            macro array computing (reported in status bit 0)
module pim_bus_slave
  import pim_bus_pkg::*;
#(
  parameter int CMD_DEPTH = 8,
  parameter int RES_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_write,
  input  logic        i_read,
  input  logic [3:0]  i_size,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_rd_data,
  output logic        o_w_valid,
  output logic        o_w_is_act,
  output logic [3:0]  o_w_sel,
  output logic [31:0] o_w_data,
  input  logic        i_w_ready,
  input  logic        i_r_valid,
  input  logic [31:0] i_r_data,
  output logic        o_r_ready,
  input  logic        i_pim_busy
);

  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int RES_CW = $clog2(RES_DEPTH) + 1;

  logic hit_ctrl, hit_r, hit_ww, hit_wa;
  logic wr_en, rd_en;

  assign hit_ctrl = (i_addr == PIM_CTRL);
  assign hit_r    = (i_addr == PIM_R);
  assign hit_ww   = (i_addr[31:4] == PIM_W_WEIGHT[31:4]);
  assign hit_wa   = (i_addr[31:4] == PIM_W_ACTIVATION[31:4]);
  assign wr_en    = i_write;
  assign rd_en    = i_read & ~i_write;

  // Command path
  pim_cmd_t            cmd_in, cmd_head;
  logic                cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CMD_CW-1:0]   cmd_count;

  assign cmd_push = wr_en & (hit_ww | hit_wa);
  assign cmd_in   = '{is_act: hit_wa, sel: i_addr[3:0],
                      data: i_wr_data & lane_mask(i_size)};
  assign cmd_pop  = o_w_valid & i_w_ready;

  pim_sync_fifo #(.WIDTH($bits(pim_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (cmd_push),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .count     (cmd_count)
  );

  // Head storage is unreset, so the payload is forced to zero while empty.
  assign o_w_valid  = ~cmd_empty;
  assign o_w_is_act = o_w_valid & cmd_head.is_act;
  assign o_w_sel    = o_w_valid ? cmd_head.sel  : '0;
  assign o_w_data   = o_w_valid ? cmd_head.data : '0;

  // Result path
  logic                res_push, res_pop, res_full, res_empty;
  logic [31:0]         res_head;
  logic [RES_CW-1:0]   res_count;

  // Ready depends on stored state only, never on this cycle's bus pop.
  assign o_r_ready = ~res_full;
  assign res_push  = i_r_valid & o_r_ready;
  assign res_pop   = rd_en & hit_r & ~res_empty;

  pim_sync_fifo #(.WIDTH(32), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (res_push),
    .push_data (i_r_data),
    .pop       (res_pop),
    .pop_data  (res_head),
    .full      (res_full),
    .empty     (res_empty),
    .count     (res_count)
  );

  // Sticky flags and status word
  logic        ovf, udf;
  logic        set_ovf, set_udf, clr_ovf, clr_udf;
  logic [31:0] stat;
  logic [31:0] rd_next;

  assign set_ovf = cmd_push & cmd_full & ~cmd_pop;
  assign set_udf = rd_en & hit_r & res_empty;
  assign clr_ovf = wr_en & hit_ctrl & i_wr_data[STAT_OVF];
  assign clr_udf = wr_en & hit_ctrl & i_wr_data[STAT_UDF];

  // NOTE: every always_comb output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    stat             = '0;
    stat[STAT_BUSY]  = cmd_full | i_pim_busy;
    stat[STAT_VALID] = ~res_empty;
    stat[STAT_OVF]   = ovf;
    stat[STAT_UDF]   = udf;
    stat[15:8]       = 8'(cmd_count);
    stat[23:16]      = 8'(res_count);
  end

  always_comb begin
    rd_next = '0;
    if (hit_ctrl)                rd_next = stat;
    else if (hit_r && !res_empty) rd_next = res_head;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_data <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      if (rd_en) o_rd_data <= rd_next;
      // A set in the same cycle as a clear wins.
      if (set_ovf)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      if (set_udf)      udf <= 1'b1;
      else if (clr_udf) udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pim_bus_slave.sv
// Self-checking bench for pim_bus_slave: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based model of the two buffers, sticky flags and read data.
module tb_pim_bus_slave;

  localparam int CMD_DEPTH = 8;
  localparam int RES_DEPTH = 8;

  localparam logic [31:0] A_CTRL = 32'h4000_0010;
  localparam logic [31:0] A_R    = 32'h4000_0020;
  localparam logic [31:0] A_WW   = 32'h4000_0040;
  localparam logic [31:0] A_WA   = 32'h4000_0080;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_write = 1'b0;
  logic        i_read = 1'b0;
  logic [3:0]  i_size = 4'hF;
  logic [31:0] i_wr_data = '0;
  logic [31:0] o_rd_data;
  logic        o_w_valid;
  logic        o_w_is_act;
  logic [3:0]  o_w_sel;
  logic [31:0] o_w_data;
  logic        i_w_ready = 1'b0;
  logic        i_r_valid = 1'b0;
  logic [31:0] i_r_data = '0;
  logic        o_r_ready;
  logic        i_pim_busy = 1'b0;

  pim_bus_slave #(.CMD_DEPTH(CMD_DEPTH), .RES_DEPTH(RES_DEPTH)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_addr     (i_addr),
    .i_write    (i_write),
    .i_read     (i_read),
    .i_size     (i_size),
    .i_wr_data  (i_wr_data),
    .o_rd_data  (o_rd_data),
    .o_w_valid  (o_w_valid),
    .o_w_is_act (o_w_is_act),
    .o_w_sel    (o_w_sel),
    .o_w_data   (o_w_data),
    .i_w_ready  (i_w_ready),
    .i_r_valid  (i_r_valid),
    .i_r_data   (i_r_data),
    .o_r_ready  (o_r_ready),
    .i_pim_busy (i_pim_busy)
  );

  always #5 i_clk = ~i_clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic cmp_en   = 1'b0;

  // Model state
  logic [36:0] cmd_q[$];
  logic [31:0] res_q[$];
  logic        m_ovf;
  logic        m_udf;
  logic [31:0] exp_rd;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    cmd_q.delete();
    res_q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    exp_rd = '0;
  endtask

  function automatic logic [31:0] model_stat();
    int cc = cmd_q.size();
    int rc = res_q.size();
    logic [31:0] s = '0;
    if (cc == CMD_DEPTH || i_pim_busy) s = s + 32'd1;
    if (rc > 0) s = s + 32'd2;
    if (m_ovf)  s = s + 32'd4;
    if (m_udf)  s = s + 32'd8;
    s = s + 32'(cc) * 32'd256 + 32'(rc) * 32'd65536;
    return s;
  endfunction

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic model_step();
    logic [31:0] s;
    logic        pop_cmd, cmd_was_full, res_was_full, in_ww, in_wa;
    logic [31:0] masked;
    if (!i_rst_n) begin
      model_reset();
    end else begin
      s            = model_stat();
      pop_cmd      = (cmd_q.size() > 0) && i_w_ready;
      cmd_was_full = (cmd_q.size() == CMD_DEPTH);
      res_was_full = (res_q.size() == RES_DEPTH);
      in_ww = (i_addr >= A_WW) && (i_addr <= A_WW + 32'd15);
      in_wa = (i_addr >= A_WA) && (i_addr <= A_WA + 32'd15);
      masked = '0;
      for (int k = 0; k < 4; k++)
        if (i_size[k]) masked[8*k +: 8] = i_wr_data[8*k +: 8];
      if (pop_cmd) void'(cmd_q.pop_front());
      if (i_write) begin
        if (i_addr == A_CTRL) begin
          if (i_wr_data[2]) m_ovf = 1'b0;
          if (i_wr_data[3]) m_udf = 1'b0;
        end else if (in_ww || in_wa) begin
          if (!cmd_was_full || pop_cmd) cmd_q.push_back({in_wa, i_addr[3:0], masked});
          else m_ovf = 1'b1;
        end
      end else if (i_read) begin
        if (i_addr == A_CTRL) exp_rd = s;
        else if (i_addr == A_R) begin
          if (res_q.size() > 0) exp_rd = res_q.pop_front();
          else begin
            exp_rd = '0;
            m_udf  = 1'b1;
          end
        end else exp_rd = '0;
      end
      if (i_r_valid && !res_was_full) res_q.push_back(i_r_data);
    end
  endtask

  // Compare process: DUT outputs against the model, mid-cycle.
  always @(negedge i_clk) begin
    if (cmp_en) begin
      check("rd_data", o_rd_data, exp_rd);
      check("w_valid", 32'(o_w_valid), 32'(cmd_q.size() != 0));
      if (cmd_q.size() != 0 && o_w_valid) begin
        check("w_is_act", 32'(o_w_is_act), 32'(cmd_q[0][36]));
        check("w_sel", 32'(o_w_sel), 32'(cmd_q[0][35:32]));
        check("w_data", o_w_data, cmd_q[0][31:0]);
      end
      check("r_ready", 32'(o_r_ready), 32'(res_q.size() < RES_DEPTH));
    end
  end

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    i_addr    = '0;
    i_write   = 1'b0;
    i_read    = 1'b0;
    i_size    = 4'hF;
    i_wr_data = '0;
    i_r_valid = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    i_addr = a; i_wr_data = d; i_size = s; i_write = 1'b1;
    tick();
    idle();
  endtask

  task automatic bus_rd(input logic [31:0] a);
    i_addr = a; i_read = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    model_reset();
    cmp_en = 1'b1;
    repeat (3) tick();
    i_rst_n = 1'b1;

    // Post-reset state
    check("rst_w_valid", 32'(o_w_valid), 32'd0);
    check("rst_r_ready", 32'(o_r_ready), 32'd1);
    bus_rd(A_CTRL);
    check("rst_stat", o_rd_data, 32'h0000_0000);

    // Single weight write, stalled then accepted
    bus_wr(32'h4000_0043, 32'hA5A5_0001, 4'b1111);
    check("ww_valid", 32'(o_w_valid), 32'd1);
    check("ww_sel", 32'(o_w_sel), 32'd3);
    check("ww_is_act", 32'(o_w_is_act), 32'd0);
    check("ww_data", o_w_data, 32'hA5A5_0001);
    bus_rd(A_CTRL);
    check("ww_stat", o_rd_data, 32'h0000_0100);
    i_w_ready = 1'b1;
    tick();
    i_w_ready = 1'b0;
    check("ww_popped", 32'(o_w_valid), 32'd0);
    bus_rd(A_CTRL);
    check("ww_stat0", o_rd_data, 32'h0000_0000);

    // Fill the command FIFO and overflow it
    for (int i = 0; i < 8; i++) bus_wr(A_WA, 32'(i), 4'hF);
    bus_rd(A_CTRL);
    check("full_stat", o_rd_data, 32'h0000_0801);
    check("full_is_act", 32'(o_w_is_act), 32'd1);
    bus_wr(A_WA, 32'h0000_0099, 4'hF);
    bus_rd(A_CTRL);
    check("ovf_stat", o_rd_data, 32'h0000_0805);
    bus_wr(A_CTRL, 32'h0000_0004, 4'hF);
    bus_rd(A_CTRL);
    check("ovf_clr", o_rd_data, 32'h0000_0801);
    i_w_ready = 1'b1;
    repeat (8) tick();
    i_w_ready = 1'b0;
    check("drained", 32'(o_w_valid), 32'd0);

    // Results in order, then underflow
    i_r_valid = 1'b1; i_r_data = 32'h1111_1111;
    tick();
    i_r_data = 32'h2222_2222;
    tick();
    idle();
    bus_rd(A_CTRL);
    check("res_stat", o_rd_data, 32'h0002_0002);
    bus_rd(A_R);
    check("res_0", o_rd_data, 32'h1111_1111);
    bus_rd(A_R);
    check("res_1", o_rd_data, 32'h2222_2222);
    bus_rd(A_R);
    check("res_empty", o_rd_data, 32'h0000_0000);
    bus_rd(A_CTRL);
    check("udf_stat", o_rd_data, 32'h0000_0008);
    bus_wr(A_CTRL, 32'h0000_0008, 4'hF);
    bus_rd(A_CTRL);
    check("udf_clr", o_rd_data, 32'h0000_0000);

    // Busy flag and byte-lane masking
    i_pim_busy = 1'b1;
    bus_rd(A_CTRL);
    check("busy_stat", o_rd_data, 32'h0000_0001);
    i_pim_busy = 1'b0;
    bus_wr(A_WW, 32'hDEAD_BEEF, 4'b0011);
    check("mask_data", o_w_data, 32'h0000_BEEF);
    bus_wr(32'h4000_0085, 32'h1234_5678, 4'b1100);
    bus_wr(A_WW, 32'h0BAD_F00D, 4'hF);
    bus_rd(A_CTRL);
    check("three_q", o_rd_data, 32'h0000_0300);

    // Asynchronous reset mid-operation
    #2;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_w_valid", 32'(o_w_valid), 32'd0);
    check("arst_rd_data", o_rd_data, 32'h0000_0000);
    check("arst_r_ready", 32'(o_r_ready), 32'd1);
    tick();
    tick();
    i_rst_n = 1'b1;
    bus_rd(A_CTRL);
    check("arst_stat", o_rd_data, 32'h0000_0000);

    // Randomized traffic in phases biased toward filling or draining
    for (int phase = 0; phase < 4; phase++) begin
      for (int n = 0; n < 750; n++) begin
        int pick = $urandom_range(0, 9);
        case (pick)
          0, 1:    i_addr = A_CTRL;
          2, 3:    i_addr = A_R;
          4, 5:    i_addr = A_WW | 32'($urandom_range(0, 15));
          6, 7:    i_addr = A_WA | 32'($urandom_range(0, 15));
          8:       i_addr = 32'h4000_0030;
          default: i_addr = $urandom;
        endcase
        i_write    = ($urandom_range(0, 9) < 4);
        i_read     = ($urandom_range(0, 9) < 4);
        i_size     = 4'($urandom_range(0, 15));
        i_wr_data  = $urandom;
        i_w_ready  = (phase[0] == 1'b0) ? ($urandom_range(0, 9) < 2)
                                        : ($urandom_range(0, 9) < 8);
        i_r_valid  = (phase[0] == 1'b0) ? ($urandom_range(0, 9) < 7)
                                        : ($urandom_range(0, 9) < 2);
        i_r_data   = $urandom;
        i_pim_busy = ($urandom_range(0, 9) < 2);
        tick();
      end
    end
    idle();
    i_w_ready  = 1'b0;
    i_pim_busy = 1'b0;
    tick();
    @(negedge i_clk);
    #1;
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
